// File: rtl/sdio_data_buffer.sv
// rtl/sdio_data_buffer.sv - TX/RX byte FIFOs between the SDIO function layer and the data phy
module sdio_data_buffer #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic [12:0]         i_block_size,
    input  logic                i_write_flag,
    input  logic                i_tx_stb,
    input  logic [7:0]          i_tx_data,
    output logic                o_tx_full,
    output logic [ADDR_WIDTH:0] o_tx_count,
    input  logic                i_rx_stb,
    output logic [7:0]          o_rx_data,
    output logic                o_rx_empty,
    output logic [ADDR_WIDTH:0] o_rx_count,
    output logic                o_rx_overflow,
    output logic                o_crc_err,
    input  logic                i_phy_hst_rdy,
    output logic                o_phy_com_rdy,
    output logic                o_phy_rd_stb,
    output logic [7:0]          o_phy_rd_data,
    input  logic                i_phy_wr_stb,
    input  logic [7:0]          i_phy_wr_data,
    input  logic                i_phy_finished,
    input  logic                i_phy_crc_good
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} tx_state_t;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    tx_state_t   tx_state_q, tx_state_d;
    ptr_t        tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [12:0] tx_cnt_q, tx_cnt_d;
    logic        com_rdy_q, com_rdy_d;
    logic        rd_stb_q, rd_stb_d;
    logic [7:0]  rd_data_q, rd_data_d;

    ptr_t        rx_rd_ptr_q, rx_rd_ptr_d, rx_commit_ptr_q, rx_commit_ptr_d;
    ptr_t        rx_spec_ptr_q, rx_spec_ptr_d;
    logic [12:0] rx_xfer_cnt_q, rx_xfer_cnt_d;
    logic        rx_blk_ovf_q, rx_blk_ovf_d;
    logic        rx_overflow_q, rx_overflow_d;
    logic        crc_err_q, crc_err_d;
    logic        fin_q, fin_d;

    ptr_t        tx_count, tx_count_d, rx_count, rx_used;
    logic        tx_full, tx_push, tx_pop;
    logic        rx_empty, rx_full, rx_pop, rx_take, rx_write, fin_rise;
    logic [7:0]  tx_head;

    assign tx_count = tx_wr_ptr_q - tx_rd_ptr_q;
    assign tx_full  = tx_count[ADDR_WIDTH];
    assign tx_push  = i_tx_stb && !tx_full && !i_flush;
    assign tx_head  = tx_mem[tx_rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        rd_stb_d    = 1'b0;
        rd_data_d   = rd_data_q;
        tx_pop      = 1'b0;
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + ptr_t'(1);
        end
        // The handshake cycle already issues the first strobe so the block has no gap.
        case (tx_state_q)
            S_IDLE: begin
                if (i_phy_hst_rdy && com_rdy_q) begin
                    tx_state_d = S_STREAM;
                    tx_pop     = 1'b1;
                    rd_stb_d   = 1'b1;
                    rd_data_d  = tx_head;
                    tx_cnt_d   = 13'd1;
                end
            end
            S_STREAM: begin
                if (!i_phy_hst_rdy || tx_cnt_q == i_block_size) begin
                    tx_state_d = S_DONE;
                end else begin
                    tx_pop    = 1'b1;
                    rd_stb_d  = 1'b1;
                    rd_data_d = tx_head;
                    tx_cnt_d  = tx_cnt_q + 13'd1;
                end
            end
            S_DONE: begin
                if (!i_phy_hst_rdy) begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        tx_rd_ptr_d = tx_rd_ptr_q + ptr_t'(tx_pop);
        tx_count_d  = tx_wr_ptr_d - tx_rd_ptr_d;
        com_rdy_d   = (tx_state_d == S_IDLE) && !i_write_flag && (i_block_size != 13'd0)
                      && (32'(tx_count_d) >= 32'(i_block_size));
        if (i_flush) begin
            tx_state_d  = S_IDLE;
            tx_wr_ptr_d = '0;
            tx_rd_ptr_d = '0;
            tx_cnt_d    = '0;
            com_rdy_d   = 1'b0;
            rd_stb_d    = 1'b0;
            rd_data_d   = '0;
        end
    end

    assign rx_count = rx_commit_ptr_q - rx_rd_ptr_q;
    assign rx_used  = rx_spec_ptr_q - rx_rd_ptr_q;
    assign rx_empty = (rx_count == '0);
    assign rx_full  = rx_used[ADDR_WIDTH];
    assign rx_pop   = i_rx_stb && !rx_empty;
    assign rx_take  = i_phy_wr_stb && i_write_flag && (rx_xfer_cnt_q < i_block_size);
    assign rx_write = rx_take && !rx_full && !i_flush;
    assign fin_rise = i_phy_finished && !fin_q;

    always_comb begin
        rx_rd_ptr_d     = rx_rd_ptr_q + ptr_t'(rx_pop);
        rx_commit_ptr_d = rx_commit_ptr_q;
        rx_spec_ptr_d   = rx_spec_ptr_q;
        rx_xfer_cnt_d   = rx_xfer_cnt_q;
        rx_blk_ovf_d    = rx_blk_ovf_q;
        rx_overflow_d   = rx_overflow_q;
        crc_err_d       = 1'b0;
        fin_d           = i_phy_finished;
        if (rx_take) begin
            rx_xfer_cnt_d = rx_xfer_cnt_q + 13'd1;
            if (rx_full) begin
                rx_overflow_d = 1'b1;
                rx_blk_ovf_d  = 1'b1;
            end else begin
                rx_spec_ptr_d = rx_spec_ptr_q + ptr_t'(1);
            end
        end
        // A block that lost any byte to overflow is never committed.
        if (fin_rise) begin
            rx_xfer_cnt_d = '0;
            if (i_write_flag) begin
                if (i_phy_crc_good && !rx_blk_ovf_d) begin
                    rx_commit_ptr_d = rx_spec_ptr_d;
                end else begin
                    rx_spec_ptr_d = rx_commit_ptr_q;
                    crc_err_d     = 1'b1;
                end
                rx_blk_ovf_d = 1'b0;
            end
        end
        if (i_flush) begin
            rx_rd_ptr_d     = '0;
            rx_commit_ptr_d = '0;
            rx_spec_ptr_d   = '0;
            rx_xfer_cnt_d   = '0;
            rx_blk_ovf_d    = 1'b0;
            rx_overflow_d   = 1'b0;
            crc_err_d       = 1'b0;
            fin_d           = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_q[ADDR_WIDTH-1:0]] <= i_tx_data;
        end
        if (rx_write) begin
            rx_mem[rx_spec_ptr_q[ADDR_WIDTH-1:0]] <= i_phy_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q      <= S_IDLE;
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            tx_cnt_q        <= '0;
            com_rdy_q       <= 1'b0;
            rd_stb_q        <= 1'b0;
            rd_data_q       <= '0;
            rx_rd_ptr_q     <= '0;
            rx_commit_ptr_q <= '0;
            rx_spec_ptr_q   <= '0;
            rx_xfer_cnt_q   <= '0;
            rx_blk_ovf_q    <= 1'b0;
            rx_overflow_q   <= 1'b0;
            crc_err_q       <= 1'b0;
            fin_q           <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_wr_ptr_q     <= tx_wr_ptr_d;
            tx_rd_ptr_q     <= tx_rd_ptr_d;
            tx_cnt_q        <= tx_cnt_d;
            com_rdy_q       <= com_rdy_d;
            rd_stb_q        <= rd_stb_d;
            rd_data_q       <= rd_data_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            rx_commit_ptr_q <= rx_commit_ptr_d;
            rx_spec_ptr_q   <= rx_spec_ptr_d;
            rx_xfer_cnt_q   <= rx_xfer_cnt_d;
            rx_blk_ovf_q    <= rx_blk_ovf_d;
            rx_overflow_q   <= rx_overflow_d;
            crc_err_q       <= crc_err_d;
            fin_q           <= fin_d;
        end
    end

    assign o_tx_full     = tx_full;
    assign o_tx_count    = tx_count;
    assign o_rx_data     = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q[ADDR_WIDTH-1:0]];
    assign o_rx_empty    = rx_empty;
    assign o_rx_count    = rx_count;
    assign o_rx_overflow = rx_overflow_q;
    assign o_crc_err     = crc_err_q;
    assign o_phy_com_rdy = com_rdy_q;
    assign o_phy_rd_stb  = rd_stb_q;
    assign o_phy_rd_data = rd_data_q;

endmodule

// File: tb/tb_sdio_data_buffer.sv
// tb/tb_sdio_data_buffer.sv - scoreboard bench for sdio_data_buffer
module tb_sdio_data_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush;
    logic [12:0] i_block_size;
    logic        i_write_flag;
    logic        i_tx_stb;
    logic [7:0]  i_tx_data;
    logic        o_tx_full;
    logic [9:0]  o_tx_count;
    logic        i_rx_stb;
    logic [7:0]  o_rx_data;
    logic        o_rx_empty;
    logic [9:0]  o_rx_count;
    logic        o_rx_overflow;
    logic        o_crc_err;
    logic        i_phy_hst_rdy;
    logic        o_phy_com_rdy;
    logic        o_phy_rd_stb;
    logic [7:0]  o_phy_rd_data;
    logic        i_phy_wr_stb;
    logic [7:0]  i_phy_wr_data;
    logic        i_phy_finished;
    logic        i_phy_crc_good;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int tx_model = 0;
    int rx_model = 0;
    int pushes_left = 0;
    logic [7:0] pv = 8'h00;
    logic [7:0] tx_sb[$];
    logic [7:0] rx_sb[$];

    always #5 clk = ~clk;

    sdio_data_buffer #(.ADDR_WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_block_size(i_block_size),
        .i_write_flag(i_write_flag), .i_tx_stb(i_tx_stb), .i_tx_data(i_tx_data),
        .o_tx_full(o_tx_full), .o_tx_count(o_tx_count), .i_rx_stb(i_rx_stb),
        .o_rx_data(o_rx_data), .o_rx_empty(o_rx_empty), .o_rx_count(o_rx_count),
        .o_rx_overflow(o_rx_overflow), .o_crc_err(o_crc_err), .i_phy_hst_rdy(i_phy_hst_rdy),
        .o_phy_com_rdy(o_phy_com_rdy), .o_phy_rd_stb(o_phy_rd_stb), .o_phy_rd_data(o_phy_rd_data),
        .i_phy_wr_stb(i_phy_wr_stb), .i_phy_wr_data(i_phy_wr_data), .i_phy_finished(i_phy_finished),
        .i_phy_crc_good(i_phy_crc_good)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic       acc;
        logic [7:0] e;
        acc = i_tx_stb && !i_flush && (tx_model < 512);
        if (acc) tx_sb.push_back(i_tx_data);
        if (i_rx_stb && !i_flush && rx_model > 0) begin
            e = rx_sb.pop_front();
            chk("rx_data", 32'(o_rx_data), 32'(e));
            rx_model--;
        end
        @(posedge clk);
        @(negedge clk);
        if (i_flush) begin
            tx_model = 0;
            rx_model = 0;
            tx_sb.delete();
            rx_sb.delete();
        end else begin
            if (acc) tx_model++;
            if (o_phy_rd_stb) begin
                strobes++;
                chk("tx_stb_has_data", 32'(tx_sb.size() != 0), 1);
                if (tx_sb.size() != 0) begin
                    e = tx_sb.pop_front();
                    chk("tx_rd_data", 32'(o_phy_rd_data), 32'(e));
                    tx_model--;
                end
            end
        end
        chk("tx_count", 32'(o_tx_count), tx_model);
        chk("tx_full", 32'(o_tx_full), 32'(tx_model == 512));
        chk("rx_count", 32'(o_rx_count), rx_model);
        chk("rx_empty", 32'(o_rx_empty), 32'(rx_model == 0));
    endtask

    task automatic tx_feed();
        i_tx_stb = (pushes_left > 0) && (tx_model < 512);
        i_tx_data = pv;
        if (i_tx_stb) begin
            pushes_left--;
            pv = pv + 8'd1;
        end
    endtask

    task automatic stream_block(input int n);
        i_phy_hst_rdy = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            chk("tx_stream_contig", 32'(o_phy_rd_stb), 1);
        end
        step();
        chk("tx_done_no_stb", 32'(o_phy_rd_stb), 0);
        i_phy_hst_rdy = 1'b0;
        step();
    endtask

    task automatic rx_block(input int n, input logic [7:0] base, input logic good, input logic pop_en);
        logic [7:0] blk[$];
        logic       ovf = 1'b0;
        i_write_flag = 1'b1;
        for (int i = 0; i < n; i++) begin
            i_phy_wr_stb  = 1'b1;
            i_phy_wr_data = 8'(base + 8'(i));
            i_rx_stb      = pop_en && (rx_model > 0);
            if (rx_model + blk.size() >= 512) ovf = 1'b1;
            else blk.push_back(i_phy_wr_data);
            step();
        end
        i_phy_wr_stb   = 1'b0;
        i_rx_stb       = 1'b0;
        i_phy_finished = 1'b1;
        i_phy_crc_good = good;
        if (good && !ovf) begin
            foreach (blk[j]) rx_sb.push_back(blk[j]);
            rx_model += blk.size();
        end
        step();
        chk("rx_crc_err_pulse", 32'(o_crc_err), 32'(!(good && !ovf)));
        if (ovf) chk("rx_overflow_set", 32'(o_rx_overflow), 1);
        i_phy_finished = 1'b0;
        i_phy_crc_good = 1'b0;
        step();
        chk("rx_crc_err_clear", 32'(o_crc_err), 0);
    endtask

    task automatic rx_drain();
        int k = 0;
        while (rx_model > 0 && k < 1000) begin
            i_rx_stb = 1'b1;
            step();
            k++;
        end
        i_rx_stb = 1'b0;
        chk("rx_drained", 32'(o_rx_empty), 1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_full"}, 32'(o_tx_full), 0);
        chk({tag, "_tx_count"}, 32'(o_tx_count), 0);
        chk({tag, "_rx_empty"}, 32'(o_rx_empty), 1);
        chk({tag, "_rx_count"}, 32'(o_rx_count), 0);
        chk({tag, "_rx_overflow"}, 32'(o_rx_overflow), 0);
        chk({tag, "_crc_err"}, 32'(o_crc_err), 0);
        chk({tag, "_com_rdy"}, 32'(o_phy_com_rdy), 0);
        chk({tag, "_rd_stb"}, 32'(o_phy_rd_stb), 0);
        chk({tag, "_rd_data"}, 32'(o_phy_rd_data), 0);
        chk({tag, "_rx_data"}, 32'(o_rx_data), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s0;
        rst_n = 1'b0; i_flush = 1'b0; i_block_size = 13'd512; i_write_flag = 1'b0;
        i_tx_stb = 1'b0; i_tx_data = 8'h00; i_rx_stb = 1'b0; i_phy_hst_rdy = 1'b0;
        i_phy_wr_stb = 1'b0; i_phy_wr_data = 8'h00; i_phy_finished = 1'b0; i_phy_crc_good = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Full 512-byte block, push while full is dropped, then stream out.
        for (int i = 0; i < 512; i++) begin
            i_tx_stb = 1'b1;
            i_tx_data = 8'(i);
            step();
        end
        chk("full_com_rdy", 32'(o_phy_com_rdy), 1);
        i_tx_data = 8'hEE;
        step();
        i_tx_stb = 1'b0;
        chk("full_count_after_drop", 32'(o_tx_count), 512);
        stream_block(512);
        chk("full_drained", 32'(o_tx_count), 0);

        // Threshold: 63 bytes not enough for a 64-byte block.
        i_block_size = 13'd64;
        for (int i = 0; i < 63; i++) begin
            i_tx_stb = 1'b1;
            i_tx_data = 8'(8'h40 + 8'(i));
            step();
        end
        chk("com_rdy_63", 32'(o_phy_com_rdy), 0);
        i_tx_data = 8'h7F;
        step();
        i_tx_stb = 1'b0;
        chk("com_rdy_64", 32'(o_phy_com_rdy), 1);
        stream_block(64);

        // RX good block, bad block, then good block.
        i_block_size = 13'd16;
        rx_block(16, 8'hA0, 1'b1, 1'b0);
        chk("rx_good_count", 32'(o_rx_count), 16);
        rx_drain();
        rx_block(16, 8'hA0, 1'b0, 1'b0);
        chk("rx_bad_count", 32'(o_rx_count), 0);
        rx_block(16, 8'h10, 1'b1, 1'b0);
        chk("rx_head_after_bad", 32'(o_rx_data), 32'h10);
        rx_drain();

        // Overflow on top of 500 committed bytes, then flush.
        i_block_size = 13'd500;
        rx_block(500, 8'h00, 1'b1, 1'b0);
        i_block_size = 13'd16;
        rx_block(16, 8'hC0, 1'b1, 1'b0);
        chk("ovf_count_500", 32'(o_rx_count), 500);
        chk("ovf_sticky", 32'(o_rx_overflow), 1);
        i_write_flag = 1'b0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk_reset_values("flush");

        // Pointer wrap: 40 TX blocks with concurrent pushes.
        i_block_size = 13'd64;
        pushes_left = 40 * 64;
        pv = 8'h00;
        for (int b = 0; b < 40; b++) begin
            k = 0;
            while (!o_phy_com_rdy && k < 200) begin tx_feed(); step(); k++; end
            chk("wrap_com_rdy", 32'(o_phy_com_rdy), 1);
            i_phy_hst_rdy = 1'b1;
            s0 = strobes;
            k = 0;
            while (strobes - s0 < 64 && k < 200) begin tx_feed(); step(); k++; end
            chk("wrap_block_strobes", strobes - s0, 64);
            tx_feed(); step();
            chk("wrap_done_no_stb", 32'(o_phy_rd_stb), 0);
            i_phy_hst_rdy = 1'b0;
            tx_feed(); step();
        end
        i_tx_stb = 1'b0;
        chk("wrap_tx_sb_empty", tx_sb.size(), 0);

        // Pointer wrap: 40 RX blocks with concurrent pops.
        for (int b = 0; b < 40; b++) rx_block(64, 8'(b * 7), 1'b1, 1'b1);
        rx_drain();
        i_write_flag = 1'b0;

        // Abort after 10 strobes.
        pushes_left = 64;
        k = 0;
        while (!o_phy_com_rdy && k < 200) begin tx_feed(); step(); k++; end
        i_tx_stb = 1'b0;
        chk("abort_com_rdy", 32'(o_phy_com_rdy), 1);
        i_phy_hst_rdy = 1'b1;
        s0 = strobes;
        k = 0;
        while (strobes - s0 < 10 && k < 50) begin step(); k++; end
        i_phy_hst_rdy = 1'b0;
        step();
        step();
        chk("abort_count_54", 32'(o_tx_count), 54);
        chk("abort_no_stb", 32'(o_phy_rd_stb), 0);

        // Reset mid-stream.
        i_block_size = 13'd20;
        i_phy_hst_rdy = 1'b1;
        repeat (4) step();
        chk("pre_reset_streaming", 32'(o_phy_rd_stb), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        i_phy_hst_rdy = 1'b0;
        tx_model = 0;
        rx_model = 0;
        tx_sb.delete();
        rx_sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_no_stb", 32'(o_phy_rd_stb), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdio_data_buffer.md
# sdio_data_buffer

Byte buffer between the SDIO function layer and `sdio_data_phy`. It holds two single-clock FIFOs:
- TX (card→host) is filled by the function and streamed into the phy's read-data strobe interface one whole block at a time.
- RX (host→card) captures the phy's write strobes into a speculative region. It commits the block only when the phy reports a good CRC, and discards it otherwise.

## Interface
- `ADDR_WIDTH`, 9: log2 of each FIFO depth (512 bytes).
- `clk` in 1: single clock, same as the phy `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_flush` in 1: synchronous clear of both FIFOs and all state.
- `i_block_size` in 13: bytes per block. This is the same value the phy receives as `i_data_count`.
- `i_write_flag` in 1: 1 means host→card transfer, 0 means card→host.
- `i_tx_stb` in 1: push `i_tx_data` into TX.
- `i_tx_data` in 8: TX push data.
- `o_tx_full` out 1: TX full.
- `o_tx_count` out ADDR_WIDTH+1: TX occupancy.
- `i_rx_stb` in 1: pop RX.
- `o_rx_data` out 8: RX head byte, first-word-fall-through.
- `o_rx_empty` out 1: no committed RX bytes.
- `o_rx_count` out ADDR_WIDTH+1: committed RX bytes.
- `o_rx_overflow` out 1: sticky; cleared by `i_flush`.
- `o_crc_err` out 1: one-cycle pulse when a received block is discarded.
- `i_phy_hst_rdy` in 1: phy `o_data_hst_rdy`.
- `o_phy_com_rdy` out 1: to phy `i_data_com_rdy`.
- `o_phy_rd_stb` out 1: to phy `i_data_rd_stb`.
- `o_phy_rd_data` out 8: to phy `i_data_rd_data`.
- `i_phy_wr_stb` in 1: phy `o_data_wr_stb`.
- `i_phy_wr_data` in 8: phy `o_data_wr_data`.
- `i_phy_finished` in 1: phy `o_finished`.
- `i_phy_crc_good` in 1: phy `o_data_crc_good`.

## Operation
**Reset and flush**
- `rst_n` low forces every register to its reset value.
- All outputs reset to 0, except `o_rx_empty`, which resets to 1.
- `i_flush` produces the same result synchronously. It has priority over every other input in the same cycle.

**TX FIFO**
- Storage is 2^ADDR_WIDTH bytes with a binary read pointer and write pointer. The pointers wrap modulo the depth.
- A push while `o_tx_full` is asserted is dropped.
- Push and pop in the same cycle leave the count unchanged.

**TX stream FSM**, states `IDLE`, `STREAM`, `DONE`:
- **IDLE**
  - `o_phy_com_rdy` is registered. It is 1 when all of these hold:
    - state is `IDLE`
    - `i_write_flag` is 0
    - `i_block_size` is not 0
    - `o_tx_count` ≥ `i_block_size`
  - If `i_block_size` exceeds the FIFO depth, `o_phy_com_rdy` never asserts.
  - When `i_phy_hst_rdy` and `o_phy_com_rdy` are both 1: go to `STREAM`, clear the byte counter, deassert `o_phy_com_rdy`.
- **STREAM**
  - Every cycle: `o_phy_rd_stb` is 1, `o_phy_rd_data` is the FIFO head, the read pointer advances, and the counter increments.
  - After exactly `i_block_size` strobes, go to `DONE`.
  - `i_phy_hst_rdy` falling mid-stream (the phy aborted): stop immediately and go to `DONE`. Bytes already popped are lost.
- **DONE**
  - `o_phy_rd_stb` is 0.
  - When `i_phy_hst_rdy` is 0, return to `IDLE`.

**RX FIFO**
- Three pointers:
  - `rd_ptr`
  - `commit_ptr`
  - `spec_ptr`
- `o_rx_count` = `commit_ptr` − `rd_ptr`.
- The full test uses `spec_ptr` − `rd_ptr` = depth.
- On `i_phy_wr_stb` with `i_write_flag` = 1:
  - If not full, write the byte at `spec_ptr` and increment `spec_ptr`.
  - If full, drop the byte and set `o_rx_overflow`.
- At most `i_block_size` bytes are accepted per transfer. Further strobes before finish are ignored.
- The transfer's byte counter clears at the rising edge of `i_phy_finished`.

**Commit / rollback**
- Both actions apply only on the rising edge of `i_phy_finished` with `i_write_flag` = 1. `i_phy_crc_good` is sampled in that same cycle.
- `i_phy_crc_good` = 1: `commit_ptr` ← `spec_ptr`.
- `i_phy_crc_good` = 0: `spec_ptr` ← `commit_ptr`, and `o_crc_err` pulses for 1 cycle.
- An overflowed block is always rolled back, regardless of `i_phy_crc_good`.
- The `i_phy_finished` rising edge is ignored when `i_write_flag` = 0.

**Concurrency and visibility**
- `i_rx_stb` may pop committed data concurrently with speculative writes.
- A pop while `o_rx_empty` is asserted is ignored.
- Speculative bytes are never visible at `o_rx_data`.

## Timing
- `o_phy_com_rdy` reflects TX occupancy 1 cycle after the push that satisfied the condition.
- The first `o_phy_rd_stb` is issued 1 cycle after the cycle in which `i_phy_hst_rdy` and `o_phy_com_rdy` were both sampled high.
- Strobes are contiguous, one byte per clock, with no bubbles. `o_phy_rd_data` is registered with its strobe.
- `o_tx_full` and `o_tx_count` update in the cycle after a push or pop.
- Committed RX bytes appear on `o_rx_count` and `o_rx_empty` 1 cycle after the `i_phy_finished` rising edge.
- `o_rx_data` is valid whenever `o_rx_empty` is 0, and shows the next byte the cycle after a pop.
- Reset mid-stream: all strobes stop within the reset assertion; no partial commit.

## Test plan
- Push 512 bytes (0x00..0xFF twice) with `i_block_size` = 512:
  - `o_tx_full` = 1, `o_phy_com_rdy` = 1.
  - Raise `i_phy_hst_rdy` → 512 contiguous strobes with data 0x00..0xFF twice, then `DONE`, then `o_tx_count` = 0.
- `i_block_size` = 64 with 63 bytes pushed: `o_phy_com_rdy` stays 0. Push the 64th byte: `o_phy_com_rdy` = 1 the next cycle.
- Write transfer, 16 bytes 0xA0..0xAF, finished with CRC good: `o_rx_count` goes 0→16 in one step. Popping yields 0xA0..0xAF in order.
- Same transfer with `i_phy_crc_good` = 0: `o_crc_err` pulses once and `o_rx_count` stays 0. The next good block of 0x10..0x1F reads back exactly 0x10..0x1F.
- RX holding 500 committed bytes, then a 16-byte block arrives: `o_rx_overflow` = 1, block rolled back, `o_rx_count` = 500. `i_flush` clears everything to reset values.
- Pointer wrap:
  - Run 40 TX blocks of 64 bytes, with push concurrent with stream.
  - Run 40 RX blocks of 64 bytes.
  - All data matches the sent data and counts never exceed 512.
  - Abort by dropping `i_phy_hst_rdy` after 10 strobes → `o_tx_count` decreases by exactly 10.
